cache_arbiter: RTL and testbench

Shares the single line-granular physical-memory port between the instruction cache (fetch side) and the data cache (memory stage) of the pipelined RV32I core. Accepts at most one outstanding line transaction and forwards it to memory with latched address and data. Returns the response only to the granted requester. Breaks simultaneous-request ties round-robin, so neither fetch nor load/store starves while stall_fetch or stall_decode is held.

---
 rtl/cache_types.sv | 16 +
 rtl/cache_arbiter.sv | 100 ++++++++++
 tb/tb_cache_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types.sv
// Shared arbiter types: FSM state encoding and the last-grant record.
package cache_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one line-granular memory port between I-cache and D-cache, one transaction at a time, round-robin on ties.
// Strobe 1 cycle after a request seen in IDLE; resp/rdata pass through combinationally; requesters hold requests until resp.
module cache_arbiter
  import cache_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};

  arb_state_t        state;
  grant_t            last_grant;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic d_req;
  logic grant_d;
  logic serve_i;
  logic serve_d;

  assign d_req = d_read | d_write;
  // On a tie the side not served last time wins.
  assign grant_d = d_req & (~i_read | (last_grant == GRANT_I));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= SERVE_D;
            addr_q   <= d_addr & LINE_MASK;
            wdata_q  <= d_wdata;
            // read+write together is resolved as the write-back
            op_write <= d_write;
          end else if (i_read) begin
            state    <= SERVE_I;
            addr_q   <= i_addr & LINE_MASK;
            op_write <= 1'b0;
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            last_grant <= GRANT_I;
            state      <= DONE;
          end
        end
        SERVE_D: begin
          if (pmem_resp) begin
            last_grant <= GRANT_D;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign serve_i = (state == SERVE_I);
  assign serve_d = (state == SERVE_D);

  assign pmem_read  = (serve_i | serve_d) & ~op_write;
  assign pmem_write = (serve_i | serve_d) & op_write;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;

  assign i_resp  = serve_i & pmem_resp;
  assign d_resp  = serve_d & pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed scenarios followed by randomized traffic against a grant-order reference model.
module tb_cache_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [31:0] AMASK = 32'hFFFF_FFE0;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write, pmem_resp;
  logic              i_resp, d_resp, pmem_read, pmem_write;
  logic [ADDR_W-1:0] i_addr, d_addr, pmem_addr;
  logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_resp_cyc = -100;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the active edge; sample point: settle afterwards.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pmem_read"}, pmem_read, 1'b0);
    chk({tag, "_pmem_write"}, pmem_write, 1'b0);
    chk({tag, "_pmem_addr"}, pmem_addr, '0);
    chk({tag, "_pmem_wdata"}, pmem_wdata, '0);
    chk({tag, "_i_resp"}, i_resp, 1'b0);
    chk({tag, "_d_resp"}, d_resp, 1'b0);
    chk({tag, "_i_rdata"}, i_rdata, '0);
    chk({tag, "_d_rdata"}, d_rdata, '0);
  endtask

  // Entered at a drive point; waits for a strobe, answers it, returns 0 for I / 1 for D.
  task automatic serve_one(input logic [255:0] rd, output int side);
    int n;
    n = 0;
    side = -1;
    settle;
    while (!(pmem_read || pmem_write) && n < 20) begin
      tick;
      settle;
      n++;
    end
    chk("serve_strobe_seen", pmem_read | pmem_write, 1'b1);
    chk("serve_gap_ge3", (cyc - last_resp_cyc) >= 3, 1'b1);
    tick;
    pmem_resp = 1'b1;
    pmem_rdata = rd;
    settle;
    chk("serve_resp_onehot", i_resp ^ d_resp, 1'b1);
    if (i_resp) side = 0;
    else if (d_resp) side = 1;
    chk("serve_rdata", (side == 0) ? i_rdata : d_rdata, rd);
    chk("serve_other_rdata_zero", (side == 0) ? d_rdata : i_rdata, '0);
    last_resp_cyc = cyc;
    tick;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    if (side == 0) i_read = 1'b0;
    else if (side == 1) begin
      d_read = 1'b0;
      d_write = 1'b0;
    end
  endtask

  // Random-phase model state
  logic        strobe, strobe_q, prev_i, prev_d, last_i, i_got, d_got, exp_wr;
  logic [31:0] exp_addr;
  logic [255:0] exp_wd;
  int          side, wait_cnt, i_wait, d_wait;
  int          served [2];

  initial begin
    logic [255:0] rd;
    rst = 1'b1;
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
    tick;
    tick;
    rst = 1'b0;
    settle;
    chk_all_zero("reset");

    // Lone I fill
    tick;
    i_read = 1'b1;
    i_addr = 32'h0000_1234;
    settle;
    chk("lone_no_strobe_yet", pmem_read, 1'b0);
    tick;
    settle;
    chk("lone_pmem_read", pmem_read, 1'b1);
    chk("lone_pmem_write", pmem_write, 1'b0);
    chk("lone_pmem_addr", pmem_addr, 32'h0000_1220);
    tick;
    pmem_resp = 1'b1;
    pmem_rdata = {32{8'hAA}};
    settle;
    chk("lone_i_resp", i_resp, 1'b1);
    chk("lone_i_rdata", i_rdata, {32{8'hAA}});
    chk("lone_d_resp", d_resp, 1'b0);
    chk("lone_d_rdata", d_rdata, '0);
    tick;
    pmem_resp = 1'b0;
    i_read = 1'b0;
    settle;
    chk("lone_done_no_resp", i_resp, 1'b0);
    chk("lone_done_no_strobe", pmem_read, 1'b0);
    last_resp_cyc = cyc - 1;
    tick;

    // Tie right after reset goes to D, then I
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    i_read = 1'b1; i_addr = 32'h0000_0100;
    d_read = 1'b1; d_addr = 32'h0000_0200;
    serve_one(rand256(), side);
    chk("tie_first_is_d", side, 1);
    tick;
    serve_one(rand256(), side);
    chk("tie_second_is_i", side, 0);
    tick;

    // Alternation with both sides continuously re-requesting
    i_read = 1'b1;
    d_read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      serve_one(rand256(), side);
      chk("alt_grant_order", side, (k % 2 == 0) ? 1 : 0);
      if (k < 5) begin
        tick;
        if (side == 0) i_read = 1'b1;
        else d_read = 1'b1;
      end
    end
    i_read = 1'b0;
    d_read = 1'b0;
    tick;
    tick;

    // Write-back with wdata changed mid-serve
    d_write = 1'b1;
    d_addr = 32'h8000_0040;
    d_wdata = {16{16'h5555}};
    tick;
    settle;
    chk("wb_pmem_write", pmem_write, 1'b1);
    chk("wb_pmem_read", pmem_read, 1'b0);
    chk("wb_pmem_addr", pmem_addr, 32'h8000_0040);
    chk("wb_pmem_wdata", pmem_wdata, {16{16'h5555}});
    tick;
    d_wdata = '1;
    d_addr = 32'h1111_1100;
    settle;
    chk("wb_wdata_latched", pmem_wdata, {16{16'h5555}});
    chk("wb_addr_latched", pmem_addr, 32'h8000_0040);
    tick;
    rd = rand256();
    pmem_resp = 1'b1;
    pmem_rdata = rd;
    settle;
    chk("wb_wdata_at_resp", pmem_wdata, {16{16'h5555}});
    chk("wb_d_resp", d_resp, 1'b1);
    chk("wb_i_resp", i_resp, 1'b0);
    chk("wb_d_rdata", d_rdata, rd);
    tick;
    pmem_resp = 1'b0;
    d_write = 1'b0;
    tick;

    // Read and write together resolve as a write
    d_read = 1'b1;
    d_write = 1'b1;
    d_addr = 32'h0000_0047;
    tick;
    settle;
    chk("both_is_write", pmem_write, 1'b1);
    chk("both_not_read", pmem_read, 1'b0);
    chk("both_addr_aligned", pmem_addr, 32'h0000_0040);
    tick;
    pmem_resp = 1'b1;
    settle;
    chk("both_d_resp", d_resp, 1'b1);
    tick;
    pmem_resp = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
    tick;

    // Reset during SERVE_I; a late pmem_resp must be dropped
    i_read = 1'b1;
    i_addr = 32'h0000_3000;
    tick;
    settle;
    chk("rmid_serving", pmem_read, 1'b1);
    tick;
    rst = 1'b1;
    settle;
    chk("rmid_sync_reset_waits_edge", pmem_read, 1'b1);
    tick;
    rst = 1'b0;
    i_read = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = rand256();
    settle;
    chk_all_zero("rmid");
    tick;
    pmem_resp = 1'b0;
    settle;
    chk("rmid_stays_idle", pmem_read, 1'b0);

    // Stray response in IDLE: ignored, and a following request sees normal latency
    tick;
    pmem_resp = 1'b1;
    pmem_rdata = rand256();
    settle;
    chk("stray_i_resp", i_resp, 1'b0);
    chk("stray_d_resp", d_resp, 1'b0);
    chk("stray_d_rdata", d_rdata, '0);
    tick;
    pmem_resp = 1'b0;
    d_read = 1'b1;
    d_addr = 32'h0000_4000;
    settle;
    chk("stray_no_strobe", pmem_read | pmem_write, 1'b0);
    tick;
    settle;
    chk("stray_then_read", pmem_read, 1'b1);
    chk("stray_then_addr", pmem_addr, 32'h0000_4000);
    tick;
    pmem_resp = 1'b1;
    settle;
    chk("stray_then_d_resp", d_resp, 1'b1);
    tick;
    pmem_resp = 1'b0;
    d_read = 1'b0;
    tick;

    // Randomized traffic checked against a grant-order model
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    settle;
    strobe_q = 1'b0; prev_i = 1'b0; prev_d = 1'b0; last_i = 1'b1;
    i_got = 1'b0; d_got = 1'b0; wait_cnt = 0; i_wait = 0; d_wait = 0;
    side = -1; exp_addr = '0; exp_wr = 1'b0; exp_wd = '0;
    served[0] = 0; served[1] = 0;
    last_resp_cyc = -100;
    for (int c = 0; c < 2000; c++) begin
      tick;
      if (i_got) begin
        i_read = 1'b0;
        i_got = 1'b0;
      end else if (!i_read && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1;
        i_addr = $urandom;
        i_wait = 0;
      end
      if (d_got) begin
        d_read = 1'b0;
        d_write = 1'b0;
        d_got = 1'b0;
      end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) d_write = 1'b1;
        else d_read = 1'b1;
        d_addr = $urandom;
        d_wdata = rand256();
        d_wait = 0;
      end
      if (i_read) i_wait++;
      if (d_read || d_write) d_wait++;
      strobe = pmem_read | pmem_write;
      if (strobe && !strobe_q) wait_cnt = $urandom_range(0, 3);
      pmem_resp = 1'b0;
      if (strobe) begin
        if (wait_cnt == 0) begin
          pmem_resp = 1'b1;
          pmem_rdata = rand256();
        end else wait_cnt--;
      end else if ($urandom_range(0, 9) == 0) begin
        pmem_resp = 1'b1;
        pmem_rdata = rand256();
      end
      settle;
      strobe = pmem_read | pmem_write;
      chk("rnd_no_dual_strobe", pmem_read & pmem_write, 1'b0);
      if (strobe && !strobe_q) begin
        chk("rnd_strobe_has_request", prev_i | prev_d, 1'b1);
        if (prev_i && prev_d) side = last_i ? 1 : 0;
        else side = prev_d ? 1 : 0;
        chk("rnd_gap_ge3", (c - last_resp_cyc) >= 3, 1'b1);
        if (side == 0) begin
          exp_addr = i_addr & AMASK;
          exp_wr = 1'b0;
        end else begin
          exp_addr = d_addr & AMASK;
          exp_wr = d_write;
          exp_wd = d_wdata;
        end
      end
      if (strobe) begin
        chk("rnd_pmem_addr", pmem_addr, exp_addr);
        chk("rnd_pmem_write", pmem_write, exp_wr);
        if (exp_wr) chk("rnd_pmem_wdata", pmem_wdata, exp_wd);
      end
      chk("rnd_i_resp", i_resp, pmem_resp && strobe && side == 0);
      chk("rnd_d_resp", d_resp, pmem_resp && strobe && side == 1);
      chk("rnd_i_rdata", i_rdata, (pmem_resp && strobe && side == 0) ? pmem_rdata : '0);
      chk("rnd_d_rdata", d_rdata, (pmem_resp && strobe && side == 1) ? pmem_rdata : '0);
      if (pmem_resp && strobe) begin
        last_i = (side == 0);
        served[side]++;
        last_resp_cyc = c;
        if (side == 0) begin
          i_got = 1'b1;
          chk("rnd_i_wait_bounded", i_wait <= 16, 1'b1);
        end else begin
          d_got = 1'b1;
          chk("rnd_d_wait_bounded", d_wait <= 16, 1'b1);
        end
      end
      prev_i = i_read;
      prev_d = d_read | d_write;
      strobe_q = strobe;
    end
    chk("rnd_i_served", served[0] > 20, 1'b1);
    chk("rnd_d_served", served[1] > 20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
